// File: rtl/alu_issue_if.sv
// Bundle of the request, ALU and result signals of the alu_issue block.
// Valid/ready rule for both channels: a transfer happens on the rising clock edge where valid and ready are both high.
interface alu_issue_if #(
    parameter int DW = 32,
    parameter int TW = 5
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic [2:0]    alu_op_i;
    logic [5:0]    funct_i;
    logic [1:0]    br_type_i;
    logic [DW-1:0] src1_i;
    logic [DW-1:0] src2_i;
    logic [TW-1:0] tag_i;

    logic [DW-1:0] alu_src1_o;
    logic [DW-1:0] alu_src2_o;
    logic [3:0]    alu_ctrl_o;
    logic [DW-1:0] alu_result_i;
    logic          alu_zero_i;

    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] res_o;
    logic          zero_o;
    logic          taken_o;
    logic          illegal_o;
    logic [TW-1:0] tag_o;

    logic [1:0]    state_o;

    modport slave (
        input  in_valid_i, alu_op_i, funct_i, br_type_i, src1_i, src2_i, tag_i,
        input  alu_result_i, alu_zero_i, out_ready_i,
        output in_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
        output out_valid_o, res_o, zero_o, taken_o, illegal_o, tag_o, state_o
    );

    modport master (
        output in_valid_i, alu_op_i, funct_i, br_type_i, src1_i, src2_i, tag_i,
        output alu_result_i, alu_zero_i, out_ready_i,
        input  in_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
        input  out_valid_o, res_o, zero_o, taken_o, illegal_o, tag_o, state_o
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/decode front end for the 32-bit ALU: decodes the control code, registers operands,
// captures result/zero, resolves branch-taken and returns a tagged result.
module alu_issue #(
    parameter int DW = 32,
    parameter int TW = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    alu_issue_if.slave  bus
);
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_XOR = 4'd15;

    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] src1_q;
    logic [DW-1:0] src2_q;
    logic [3:0]    ctrl_q;
    logic [1:0]    br_q;
    logic [TW-1:0] tag_q;
    logic          illegal_q;
    logic [DW-1:0] res_q;
    logic          zero_q;
    logic          taken_q;
    logic          out_valid_q;

    logic [3:0]    dec_ctrl;
    logic          dec_illegal;
    logic          ready;
    logic          accept;

    // Undecodable operations still run as ADD; only the illegal flag marks them.
    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_illegal = 1'b0;
        case (bus.alu_op_i)
            3'b000: dec_ctrl = ALU_ADD;
            3'b001: dec_ctrl = ALU_SUB;
            3'b010: begin
                case (bus.funct_i)
                    6'h20:   dec_ctrl = ALU_ADD;
                    6'h22:   dec_ctrl = ALU_SUB;
                    6'h24:   dec_ctrl = ALU_AND;
                    6'h25:   dec_ctrl = ALU_OR;
                    6'h26:   dec_ctrl = ALU_XOR;
                    6'h27:   dec_ctrl = ALU_NOR;
                    6'h2A:   dec_ctrl = ALU_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            3'b011: dec_ctrl = ALU_AND;
            3'b100: dec_ctrl = ALU_OR;
            3'b101: dec_ctrl = ALU_SLT;
            3'b110: dec_ctrl = ALU_XOR;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Ready is forced low while reset is held; in DONE it follows the consumer so a
    // new request can enter on the same edge the old result leaves.
    assign ready  = rst_i && ((state == IDLE) || ((state == DONE) && bus.out_ready_i));
    assign accept = bus.in_valid_i && ready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            src1_q      <= '0;
            src2_q      <= '0;
            ctrl_q      <= '0;
            br_q        <= '0;
            tag_q       <= '0;
            illegal_q   <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            taken_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                src1_q    <= bus.src1_i;
                src2_q    <= bus.src2_i;
                ctrl_q    <= dec_ctrl;
                br_q      <= bus.br_type_i;
                tag_q     <= bus.tag_i;
                illegal_q <= dec_illegal;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_q       <= bus.alu_result_i;
                    zero_q      <= bus.alu_zero_i;
                    taken_q     <= ((br_q == BR_BEQ) && bus.alu_zero_i) ||
                                   ((br_q == BR_BNE) && !bus.alu_zero_i);
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state       <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = ready;
    assign bus.alu_src1_o  = src1_q;
    assign bus.alu_src2_o  = src2_q;
    assign bus.alu_ctrl_o  = ctrl_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.res_o       = res_q;
    assign bus.zero_o      = zero_q;
    assign bus.taken_o     = taken_q;
    assign bus.illegal_o   = illegal_q;
    assign bus.tag_o       = tag_q;
    assign bus.state_o     = state;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: decode table vectors, backpressure, async reset, streaming and a
// randomized run scored against an arithmetic reference model.
module tb_alu_issue;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int N_RAND = 60;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [39:0] exp_q[$];

    always #5 clk = ~clk;

    alu_issue_if #(.DW(DW), .TW(TW)) bus ();

    alu_issue #(.DW(DW), .TW(TW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Behavioural ALU: SLT is an unsigned compare.
    always_comb begin
        case (bus.alu_ctrl_o)
            4'd0:    bus.alu_result_i = bus.alu_src1_o & bus.alu_src2_o;
            4'd1:    bus.alu_result_i = bus.alu_src1_o | bus.alu_src2_o;
            4'd2:    bus.alu_result_i = bus.alu_src1_o + bus.alu_src2_o;
            4'd6:    bus.alu_result_i = bus.alu_src1_o - bus.alu_src2_o;
            4'd7:    bus.alu_result_i = (bus.alu_src1_o < bus.alu_src2_o) ? 32'd1 : 32'd0;
            4'd12:   bus.alu_result_i = ~(bus.alu_src1_o | bus.alu_src2_o);
            4'd15:   bus.alu_result_i = bus.alu_src1_o ^ bus.alu_src2_o;
            default: bus.alu_result_i = '0;
        endcase
    end
    assign bus.alu_zero_i = (bus.alu_result_i == '0);

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  funct;
        logic [1:0]  br;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        taken;
        logic        illegal;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: pick the operation from the op class/funct, then compute it directly.
    function automatic logic [34:0] ref_model(input logic [2:0] op, input logic [5:0] fn,
                                             input logic [1:0] br, input logic [31:0] a,
                                             input logic [31:0] b);
        int          k;
        logic        ill;
        logic [31:0] r;
        logic        z;
        logic        t;
        k   = 0;
        ill = 1'b0;
        case (op)
            3'd0: k = 0;
            3'd1: k = 1;
            3'd2: begin
                if (fn == 6'h20) k = 0;
                else if (fn == 6'h22) k = 1;
                else if (fn == 6'h24) k = 2;
                else if (fn == 6'h25) k = 3;
                else if (fn == 6'h26) k = 4;
                else if (fn == 6'h27) k = 5;
                else if (fn == 6'h2A) k = 6;
                else ill = 1'b1;
            end
            3'd3: k = 2;
            3'd4: k = 3;
            3'd5: k = 6;
            3'd6: k = 4;
            default: ill = 1'b1;
        endcase
        case (k)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~(a | b);
            default: r = (a < b) ? 32'd1 : 32'd0;
        endcase
        z = (r == 0);
        t = ((br == 2'b01) && z) || ((br == 2'b10) && !z);
        return {r, z, t, ill};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [1:0] br,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus.in_valid_i = 1'b1;
        bus.alu_op_i   = op;
        bus.funct_i    = fn;
        bus.br_type_i  = br;
        bus.src1_i     = a;
        bus.src2_i     = b;
        bus.tag_i      = tag;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        drive(v.op, v.funct, v.br, v.a, v.b, v.tag);
        bus.out_ready_i = 1'b0;
        #1;
        chk($sformatf("v%0d in_ready idle", i), bus.in_ready_o, 1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        chk($sformatf("v%0d ctrl exec", i), bus.alu_ctrl_o, v.ctrl);
        chk($sformatf("v%0d valid exec", i), bus.out_valid_o, 0);
        chk($sformatf("v%0d ready exec", i), bus.in_ready_o, 0);
        @(negedge clk);
        chk($sformatf("v%0d valid done", i), bus.out_valid_o, 1);
        chk($sformatf("v%0d res", i), bus.res_o, v.res);
        chk($sformatf("v%0d zero", i), bus.zero_o, v.zero);
        chk($sformatf("v%0d taken", i), bus.taken_o, v.taken);
        chk($sformatf("v%0d illegal", i), bus.illegal_o, v.illegal);
        chk($sformatf("v%0d tag", i), bus.tag_o, v.tag);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk($sformatf("v%0d valid after", i), bus.out_valid_o, 0);
        chk($sformatf("v%0d ctrl held", i), bus.alu_ctrl_o, v.ctrl);
    endtask

    initial begin
        logic [31:0] ka;
        logic [31:0] kb;
        int          idx;
        int          got;
        int          last;
        int          scyc;
        int          sent;
        int          cyc;
        logic        pending;
        logic [2:0]  r_op;
        logic [5:0]  r_fn;
        logic [1:0]  r_br;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [4:0]  r_tag;
        logic [34:0] m;
        logic [39:0] e;
        logic [5:0]  fn_list[8];

        ka = 32'hF0F0_00FF;
        kb = 32'h0FF0_0F0F;
        vecs[0]  = '{3'b010, 6'h20, 2'b00, 32'd5, 32'd7, 5'd3, 4'd2, 32'd12, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 6'h00, 2'b01, 32'h1234, 32'h1234, 5'd1, 4'd6, 32'd0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'b001, 6'h00, 2'b10, 32'h1234, 32'h1234, 5'd2, 4'd6, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b001, 6'h00, 2'b10, 32'd9, 32'd4, 5'd4, 4'd6, 32'd5, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'b001, 6'h00, 2'b11, 32'h1234, 32'h1234, 5'd5, 4'd6, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b000, 6'h00, 2'b00, ka, kb, 5'd6, 4'd2, 32'h00E0_100E, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b001, 6'h00, 2'b00, ka, kb, 5'd7, 4'd6, 32'hE0FF_F1F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b010, 6'h20, 2'b00, ka, kb, 5'd8, 4'd2, 32'h00E0_100E, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 6'h22, 2'b00, ka, kb, 5'd9, 4'd6, 32'hE0FF_F1F0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b010, 6'h24, 2'b00, ka, kb, 5'd10, 4'd0, 32'h00F0_000F, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b010, 6'h25, 2'b00, ka, kb, 5'd11, 4'd1, 32'hFFF0_0FFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b010, 6'h26, 2'b00, ka, kb, 5'd12, 4'd15, 32'hFF00_0FF0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b010, 6'h27, 2'b00, ka, kb, 5'd13, 4'd12, 32'h000F_F000, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b010, 6'h2A, 2'b00, ka, kb, 5'd14, 4'd7, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{3'b011, 6'h00, 2'b00, ka, kb, 5'd15, 4'd0, 32'h00F0_000F, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b100, 6'h00, 2'b00, ka, kb, 5'd16, 4'd1, 32'hFFF0_0FFF, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'b101, 6'h00, 2'b00, ka, kb, 5'd17, 4'd7, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{3'b110, 6'h00, 2'b00, ka, kb, 5'd18, 4'd15, 32'hFF00_0FF0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{3'b111, 6'h00, 2'b00, ka, kb, 5'd19, 4'd2, 32'h00E0_100E, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{3'b010, 6'h00, 2'b00, ka, kb, 5'd20, 4'd2, 32'h00E0_100E, 1'b0, 1'b0, 1'b1};
        fn_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};

        bus.in_valid_i  = 1'b0;
        bus.alu_op_i    = '0;
        bus.funct_i     = '0;
        bus.br_type_i   = '0;
        bus.src1_i      = '0;
        bus.src2_i      = '0;
        bus.tag_i       = '0;
        bus.out_ready_i = 1'b0;

        // Reset state
        #12;
        chk("rst in_ready", bus.in_ready_o, 0);
        chk("rst out_valid", bus.out_valid_o, 0);
        chk("rst ctrl", bus.alu_ctrl_o, 0);
        chk("rst src1", bus.alu_src1_o, 0);
        chk("rst res", bus.res_o, 0);
        chk("rst tag", bus.tag_o, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", bus.in_ready_o, 1);

        for (int i = 0; i < 20; i++) run_vec(i);

        // Backpressure: op B waits while A's result is stalled
        @(negedge clk);
        drive(3'b010, 6'h20, 2'b00, 32'd5, 32'd7, 5'd3);
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        drive(3'b100, 6'h00, 2'b00, 32'h0000_00F0, 32'h0000_000F, 5'd9);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d in_ready", i), bus.in_ready_o, 0);
            chk($sformatf("bp%0d valid", i), bus.out_valid_o, 1);
            chk($sformatf("bp%0d res", i), bus.res_o, 12);
            chk($sformatf("bp%0d tag", i), bus.tag_o, 3);
            chk($sformatf("bp%0d ctrl", i), bus.alu_ctrl_o, 2);
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        #1;
        chk("bp release in_ready", bus.in_ready_o, 1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        chk("bp2 valid exec", bus.out_valid_o, 0);
        chk("bp2 ctrl", bus.alu_ctrl_o, 1);
        @(negedge clk);
        chk("bp2 valid", bus.out_valid_o, 1);
        chk("bp2 res", bus.res_o, 32'hFF);
        chk("bp2 tag", bus.tag_o, 9);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk("bp2 drained", bus.out_valid_o, 0);

        // Async reset in the middle of EXEC
        @(negedge clk);
        drive(3'b110, 6'h00, 2'b00, ka, kb, 5'd7);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst out_valid", bus.out_valid_o, 0);
        chk("arst ctrl", bus.alu_ctrl_o, 0);
        chk("arst res", bus.res_o, 0);
        chk("arst src1", bus.alu_src1_o, 0);
        chk("arst in_ready", bus.in_ready_o, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk("arst release in_ready", bus.in_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("arst no stale %0d", i), bus.out_valid_o, 0);
        end

        // Streaming with both sides always willing
        idx  = 0;
        got  = 0;
        last = 0;
        scyc = 0;
        while (got < 4 && scyc < 40) begin
            @(negedge clk);
            scyc++;
            if (idx < 4) drive(3'b000, 6'h00, 2'b00, 32'(idx), 32'd10, 5'(idx));
            else bus.in_valid_i = 1'b0;
            #1;
            if (bus.out_valid_o) begin
                chk($sformatf("stream tag %0d", got), bus.tag_o, got);
                chk($sformatf("stream res %0d", got), bus.res_o, got + 10);
                if (got > 0) chk($sformatf("stream spacing %0d", got), scyc - last, 2);
                last = scyc;
                got++;
            end
            if (bus.in_valid_i && bus.in_ready_o) idx++;
        end
        chk("stream count", got, 4);
        bus.in_valid_i = 1'b0;
        @(negedge clk);

        // Randomized run against the reference model
        sent    = 0;
        cyc     = 0;
        pending = 1'b0;
        while ((sent < N_RAND || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                r_op  = 3'($urandom_range(0, 7));
                r_fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 7)];
                r_br  = 2'($urandom_range(0, 3));
                r_a   = $urandom;
                r_b   = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
                r_tag = 5'($urandom);
                pending = 1'b1;
            end
            if (pending) drive(r_op, r_fn, r_br, r_a, r_b, r_tag);
            else bus.in_valid_i = 1'b0;
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("rand spurious valid", bus.out_valid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand result", {bus.res_o, bus.zero_o, bus.taken_o, bus.illegal_o, bus.tag_o}, e);
                end
            end
            if (pending && bus.in_ready_o) begin
                m = ref_model(r_op, r_fn, r_br, r_a, r_b);
                exp_q.push_back({m, r_tag});
                sent++;
                pending = 1'b0;
            end
        end
        chk("rand sent", sent, N_RAND);
        chk("rand drained", exp_q.size(), 0);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
